// File: rtl/sw_matrix_monitor.sv
// Switch-matrix feedback checker: debounces the 6-bit feedback, decodes the connected load,
// enforces make-before-break steps and latches the first fault cause until cleared.
module sw_matrix_monitor #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] SwFb,
    input  logic       ClrFault,
    output logic [1:0] ActiveLoad,
    output logic [1:0] LastLoad,
    output logic       Transit,
    output logic       Fault,
    output logic [1:0] FaultCode
);

    localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
    localparam logic [7:0] TMO_C     = 8'(TIMEOUT);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_STEP    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    function automatic logic is_full(input logic [5:0] c);
        return (c == 6'b110000) || (c == 6'b001100) || (c == 6'b000011);
    endfunction

    // Intermediate: one switch closed, or two uppers / two lowers from different pairs.
    function automatic logic is_inter(input logic [5:0] c);
        logic single;
        logic pair_same_side;
        single         = ($countones(c) == 1);
        pair_same_side = ($countones(c) == 2) &&
                         (((c & 6'b010101) == 6'b0) || ((c & 6'b101010) == 6'b0));
        return single || pair_same_side;
    endfunction

    function automatic logic is_legal(input logic [5:0] c);
        return (c == 6'b0) || is_full(c) || is_inter(c);
    endfunction

    function automatic logic [1:0] pair_id(input logic [5:0] c);
        logic [1:0] id;
        id = 2'b00;
        case (c)
            6'b110000: id = 2'b01;
            6'b001100: id = 2'b10;
            6'b000011: id = 2'b11;
            default:   id = 2'b00;
        endcase
        return id;
    endfunction

    logic [5:0] sample_q;
    logic [5:0] acc_q;
    logic [3:0] db_cnt_q;
    logic [3:0] db_cnt_d;
    logic [7:0] tmo_cnt_q;

    logic accept;
    logic step_ok;
    logic illegal_set;
    logic step_set;
    logic tmo_set;
    logic any_set;
    logic [1:0] set_code;

    always_comb begin
        db_cnt_d = 4'd1;
        if (SwFb == sample_q) begin
            db_cnt_d = (db_cnt_q == 4'hF) ? 4'hF : db_cnt_q + 4'd1;
        end

        illegal_set = !is_legal(SwFb);
        accept      = !illegal_set && (SwFb != acc_q) && (db_cnt_d >= SETTLE_C);
        step_ok     = ($countones(acc_q ^ SwFb) == 1) ||
                      (SwFb == 6'b0) ||
                      ((acc_q == 6'b0) && is_full(SwFb));
        step_set    = accept && !step_ok;
        tmo_set     = Transit && (tmo_cnt_q == TMO_LAST);
        any_set     = illegal_set || step_set || tmo_set;

        set_code = FC_TIMEOUT;
        if (illegal_set) begin
            set_code = FC_ILLEGAL;
        end else if (step_set) begin
            set_code = FC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q   <= 6'b0;
            acc_q      <= 6'b0;
            db_cnt_q   <= 4'd0;
            tmo_cnt_q  <= 8'd0;
            ActiveLoad <= 2'b00;
            LastLoad   <= 2'b00;
            Transit    <= 1'b0;
            Fault      <= 1'b0;
            FaultCode  <= 2'b00;
        end else begin
            sample_q <= SwFb;
            db_cnt_q <= db_cnt_d;

            // Counts while the registered code is intermediate; saturates at the limit.
            if (!Transit) begin
                tmo_cnt_q <= 8'd0;
            end else if (tmo_cnt_q != TMO_C) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end

            if (accept) begin
                acc_q      <= SwFb;
                ActiveLoad <= pair_id(SwFb);
                Transit    <= is_inter(SwFb);
                if (is_full(SwFb)) begin
                    LastLoad <= pair_id(SwFb);
                end
            end

            // First cause wins; a new cause in the clear cycle beats the clear.
            if (any_set) begin
                Fault <= 1'b1;
                if (!Fault) begin
                    FaultCode <= set_code;
                end
            end else if (ClrFault) begin
                Fault     <= 1'b0;
                FaultCode <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_sw_matrix_monitor.sv
// Directed bench for sw_matrix_monitor: each stimulus cycle queues its hand-computed
// expected outputs; a monitor pops and compares them just after the following clock edge.
module tb_sw_matrix_monitor;

    logic       clk;
    logic       rst;
    logic [5:0] SwFb;
    logic       ClrFault;
    logic [1:0] ActiveLoad;
    logic [1:0] LastLoad;
    logic       Transit;
    logic       Fault;
    logic [1:0] FaultCode;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    sw_matrix_monitor #(.SETTLE(2), .TIMEOUT(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .SwFb      (SwFb),
        .ClrFault  (ClrFault),
        .ActiveLoad(ActiveLoad),
        .LastLoad  (LastLoad),
        .Transit   (Transit),
        .Fault     (Fault),
        .FaultCode (FaultCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: expected vector {ActiveLoad, LastLoad, Transit, Fault, FaultCode}
    initial begin
        exp_t       e;
        logic [7:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {ActiveLoad, LastLoad, Transit, Fault, FaultCode};
                checks++;
                if (got !== e.exp) begin
                    errors++;
                    $display("FAIL %s got al/ll/tr/f/fc=%b_%b_%b_%b_%b exp=%b_%b_%b_%b_%b",
                             e.name, got[7:6], got[5:4], got[3], got[2], got[1:0],
                             e.exp[7:6], e.exp[5:4], e.exp[3], e.exp[2], e.exp[1:0]);
                end
            end
        end
    end

    task automatic cyc(input logic [5:0] sw, input logic clr, input logic r,
                       input logic [1:0] al, input logic [1:0] ll, input logic tr,
                       input logic f, input logic [1:0] fc, input string name);
        exp_t e;
        @(negedge clk);
        SwFb     = sw;
        ClrFault = clr;
        rst      = r;
        e.exp    = {al, ll, tr, f, fc};
        e.name   = name;
        sb.push_back(e);
    endtask

    initial begin
        rst      = 1'b1;
        SwFb     = 6'b0;
        ClrFault = 1'b0;

        // Reset, then A accepted on the 2nd edge
        cyc(6'b000000, 0, 1, 2'b00, 2'b00, 0, 0, 2'b00, "t1_rst0");
        cyc(6'b000000, 0, 1, 2'b00, 2'b00, 0, 0, 2'b00, "t1_rst1");
        cyc(6'b110000, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, "t1_settle");
        cyc(6'b110000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t1_accept");
        cyc(6'b110000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t1_hold");

        // One-cycle glitch is never accepted
        cyc(6'b100000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t3_glitch");
        cyc(6'b110000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t3_back");
        cyc(6'b110000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t3_hold");

        // A -> B make-before-break
        cyc(6'b100000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t2_s1_settle");
        for (int i = 0; i < 3; i++) cyc(6'b100000, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, "t2_s1");
        for (int i = 0; i < 4; i++) cyc(6'b101000, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, "t2_s2");
        for (int i = 0; i < 4; i++) cyc(6'b001000, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, "t2_s3");
        cyc(6'b001100, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, "t2_b_settle");
        for (int i = 0; i < 3; i++) cyc(6'b001100, 0, 0, 2'b10, 2'b10, 0, 0, 2'b00, "t2_b");

        // Illegal pattern faults without debounce, then clear
        cyc(6'b100100, 0, 0, 2'b10, 2'b10, 0, 1, 2'b01, "t4_illegal");
        cyc(6'b001100, 1, 0, 2'b10, 2'b10, 0, 0, 2'b00, "t4_clear");
        cyc(6'b001100, 0, 0, 2'b10, 2'b10, 0, 0, 2'b00, "t4_hold");

        // Safe-off, back to A, then an illegal jump to C
        cyc(6'b000000, 0, 0, 2'b10, 2'b10, 0, 0, 2'b00, "t5_off_settle");
        cyc(6'b000000, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00, "t5_off");
        cyc(6'b110000, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00, "t5_a_settle");
        cyc(6'b110000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t5_a");
        cyc(6'b000011, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t5_jump_settle");
        cyc(6'b000011, 0, 0, 2'b11, 2'b11, 0, 1, 2'b10, "t5_step_fault");
        cyc(6'b000011, 0, 0, 2'b11, 2'b11, 0, 1, 2'b10, "t5_step_hold");
        cyc(6'b000011, 1, 0, 2'b11, 2'b11, 0, 0, 2'b00, "t5_clear");

        // Stall in transit: timeout fault exactly 32 edges after Transit rises
        cyc(6'b000001, 0, 0, 2'b11, 2'b11, 0, 0, 2'b00, "t5_c1_settle");
        cyc(6'b000001, 0, 0, 2'b00, 2'b11, 1, 0, 2'b00, "t5_transit_rise");
        for (int j = 1; j <= 40; j++) begin
            if (j >= 32) cyc(6'b000101, 0, 0, 2'b00, 2'b11, 1, 1, 2'b11, "t5_timeout");
            else         cyc(6'b000101, 0, 0, 2'b00, 2'b11, 1, 0, 2'b00, "t5_pre_timeout");
        end

        // Reset mid-transfer aborts tracking; NUL -> B is then legal
        cyc(6'b000000, 0, 1, 2'b00, 2'b00, 0, 0, 2'b00, "t6_rst");
        cyc(6'b110000, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, "t6_a_settle");
        cyc(6'b110000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t6_a");
        cyc(6'b100000, 0, 0, 2'b01, 2'b01, 0, 0, 2'b00, "t6_s1_settle");
        cyc(6'b100000, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, "t6_s1");
        cyc(6'b101000, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, "t6_s2_settle");
        cyc(6'b101000, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, "t6_s2");
        cyc(6'b101000, 0, 1, 2'b00, 2'b00, 0, 0, 2'b00, "t6_abort");
        cyc(6'b001100, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, "t6_b_settle");
        cyc(6'b001100, 0, 0, 2'b10, 2'b10, 0, 0, 2'b00, "t6_b");
        cyc(6'b001100, 0, 0, 2'b10, 2'b10, 0, 0, 2'b00, "t6_b_hold");

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
